// File: rtl/tx_framer.sv
// Frame transmitter: builds {header, payload} frames, walks the link through
// OFF -> TRAIN -> RUN and serialises each frame as FRAME_WIDTH/DWIDTH words.
module tx_framer #(
    parameter int DWIDTH        = 64,
    parameter int FRAME_WIDTH   = 256,
    parameter int LITTLE_ENDIAN = 1,
    parameter int TRAIN_FRAMES  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   link_enable,
    input  logic [FRAME_WIDTH-3:0] s_payload,
    input  logic                   s_ctrl,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [DWIDTH-1:0]      txdata_out,
    output logic                   sof_out,
    output logic                   tx_active
);

    localparam int NumWords = FRAME_WIDTH / DWIDTH;
    localparam int CntW     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int TrainW   = (TRAIN_FRAMES > 0) ? $clog2(TRAIN_FRAMES + 1) : 1;

    localparam logic [CntW-1:0]        LastCyc   = CntW'(NumWords - 1);
    localparam logic [1:0]             HdrData   = 2'b01;
    localparam logic [1:0]             HdrCtrl   = 2'b10;
    localparam logic [FRAME_WIDTH-1:0] IdleFrame = {HdrCtrl, {(FRAME_WIDTH - 2){1'b0}}};

    typedef enum logic [1:0] {
        StOff,
        StTrain,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cyc_q, cyc_d;
    logic [TrainW-1:0]      train_q, train_d;
    logic [FRAME_WIDTH-1:0] shift_q, shift_d;
    logic [DWIDTH-1:0]      txdata_q, txdata_d;
    logic                   sof_q, sof_d;
    logic                   active_q, active_d;

    logic                   boundary;
    logic                   accept;
    logic [FRAME_WIDTH-1:0] frame_next;
    logic [DWIDTH-1:0]      word;

    function automatic logic [DWIDTH-1:0] bit_rev(input logic [DWIDTH-1:0] w);
        logic [DWIDTH-1:0] r;
        for (int i = 0; i < DWIDTH; i++) begin
            r[i] = w[DWIDTH-1-i];
        end
        return r;
    endfunction

    assign boundary = (cyc_q == LastCyc);

    // Link state machine: transitions, handshake and choice of the next frame.
    always_comb begin
        state_d    = state_q;
        train_d    = train_q;
        s_ready    = 1'b0;
        accept     = 1'b0;
        frame_next = '0;
        if (boundary && !rst) begin
            unique case (state_q)
                StOff: begin
                    if (link_enable) begin
                        state_d = StTrain;
                        train_d = '0;
                    end
                end
                StTrain: begin
                    if (!link_enable) begin
                        state_d = StOff;
                    end else begin
                        train_d = train_q + TrainW'(1);
                        if (int'(train_q) + 1 >= TRAIN_FRAMES) begin
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    // Dropping the link wins over a pending payload.
                    if (!link_enable) begin
                        state_d = StOff;
                    end else begin
                        s_ready = 1'b1;
                        accept  = s_valid;
                    end
                end
                default: state_d = StOff;
            endcase
        end
        unique case (state_d)
            StTrain: frame_next = IdleFrame;
            StRun:   frame_next = accept ? {(s_ctrl ? HdrCtrl : HdrData), s_payload} : IdleFrame;
            default: frame_next = '0;
        endcase
    end

    // Serialiser: load a new frame at each boundary, otherwise shift out the next word.
    always_comb begin
        if (boundary) begin
            cyc_d   = '0;
            word    = frame_next[FRAME_WIDTH-1 -: DWIDTH];
            shift_d = frame_next << DWIDTH;
        end else begin
            cyc_d   = cyc_q + CntW'(1);
            word    = shift_q[FRAME_WIDTH-1 -: DWIDTH];
            shift_d = shift_q << DWIDTH;
        end
        txdata_d = (LITTLE_ENDIAN != 0) ? bit_rev(word) : word;
        sof_d    = boundary;
        active_d = (state_d == StRun);
    end

    // State and output registers; reset parks the counter on the last word so
    // the first frame period starts on the first edge after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StOff;
            cyc_q    <= LastCyc;
            train_q  <= '0;
            shift_q  <= '0;
            txdata_q <= '0;
            sof_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            train_q  <= train_d;
            shift_q  <= shift_d;
            txdata_q <= txdata_d;
            sof_q    <= sof_d;
            active_q <= active_d;
        end
    end

    assign txdata_out = txdata_q;
    assign sof_out    = sof_q;
    assign tx_active  = active_q;

endmodule

// File: tb/tb_tx_framer.sv
// Randomised bench for tx_framer: three instances (N=4 little/big endian, N=1)
// share stimulus and are compared each cycle against a frame-level model, plus
// a loopback through a behavioural bit-slip aligner.
module tb_tx_framer;

    localparam int TF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_enable;
    logic [61:0] s_payload;
    logic        s_ctrl;
    logic        s_valid;
    logic [2:0]  rdy;
    logic [2:0]  sof;
    logic [2:0]  act;
    logic [15:0] txd0;
    logic [15:0] txd1;
    logic [63:0] txd2;

    always #5 clk = ~clk;

    tx_framer #(.DWIDTH(16), .FRAME_WIDTH(64), .LITTLE_ENDIAN(1), .TRAIN_FRAMES(TF)) u_dut0 (
        .clk(clk), .rst(rst), .link_enable(link_enable), .s_payload(s_payload),
        .s_ctrl(s_ctrl), .s_valid(s_valid), .s_ready(rdy[0]), .txdata_out(txd0),
        .sof_out(sof[0]), .tx_active(act[0])
    );

    tx_framer #(.DWIDTH(16), .FRAME_WIDTH(64), .LITTLE_ENDIAN(0), .TRAIN_FRAMES(TF)) u_dut1 (
        .clk(clk), .rst(rst), .link_enable(link_enable), .s_payload(s_payload),
        .s_ctrl(s_ctrl), .s_valid(s_valid), .s_ready(rdy[1]), .txdata_out(txd1),
        .sof_out(sof[1]), .tx_active(act[1])
    );

    tx_framer #(.DWIDTH(64), .FRAME_WIDTH(64), .LITTLE_ENDIAN(1), .TRAIN_FRAMES(TF)) u_dut2 (
        .clk(clk), .rst(rst), .link_enable(link_enable), .s_payload(s_payload),
        .s_ctrl(s_ctrl), .s_valid(s_valid), .s_ready(rdy[2]), .txdata_out(txd2),
        .sof_out(sof[2]), .tx_active(act[2])
    );

    // Per-instance configuration as seen by the model.
    int nw [3] = '{4, 4, 1};
    int dw [3] = '{16, 16, 64};
    int le [3] = '{1, 0, 1};

    // Frame-level reference: mode 0 = off, 1 = train, 2 = run.
    int          mode  [3];
    int          tcnt  [3];
    int          phase [3];
    logic [63:0] frame [3];
    logic [63:0] exp_txd [3];
    logic        exp_sof [3];
    logic        exp_act [3];

    int n_checks = 0;
    int n_errors = 0;
    int rdy_cnt [3] = '{0, 0, 0};
    int sof_cnt [3] = '{0, 0, 0};

    logic        cap_en = 1'b0;
    logic        cap_on [2] = '{1'b0, 1'b0};
    bit          bitq [2][$];
    logic [63:0] frq [2][$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] obs_txd(input int d);
        case (d)
            0:       return {48'd0, txd0};
            1:       return {48'd0, txd1};
            default: return txd2;
        endcase
    endfunction

    // Word k of a 64-bit frame for a given word width and bit order.
    function automatic logic [63:0] word_of(input logic [63:0] fr, input int k, input int w,
                                            input int l);
        logic [63:0] x;
        logic [63:0] r;
        x = (fr << (k * w)) >> (64 - w);
        if (l == 0) return x;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = x[w-1-i];
        return r;
    endfunction

    // Advance the model across the coming rising edge.
    task automatic model_step();
        logic hs;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                mode[d]    = 0;
                tcnt[d]    = 0;
                phase[d]   = nw[d] - 1;
                frame[d]   = '0;
                exp_txd[d] = '0;
                exp_sof[d] = 1'b0;
                exp_act[d] = 1'b0;
            end else if (phase[d] == nw[d] - 1) begin
                hs = (mode[d] == 2) && link_enable && s_valid;
                case (mode[d])
                    0: if (link_enable) begin mode[d] = 1; tcnt[d] = 0; end
                    1: begin
                        if (!link_enable) mode[d] = 0;
                        else begin
                            tcnt[d]++;
                            if (tcnt[d] >= TF) mode[d] = 2;
                        end
                    end
                    default: if (!link_enable) mode[d] = 0;
                endcase
                if (mode[d] == 0) frame[d] = '0;
                else if (hs) frame[d] = {(s_ctrl ? 2'b10 : 2'b01), s_payload};
                else frame[d] = {2'b10, 62'd0};
                phase[d]   = 0;
                exp_sof[d] = 1'b1;
                exp_act[d] = (mode[d] == 2);
                exp_txd[d] = word_of(frame[d], 0, dw[d], le[d]);
            end else begin
                phase[d]++;
                exp_sof[d] = 1'b0;
                exp_txd[d] = word_of(frame[d], phase[d], dw[d], le[d]);
            end
        end
    endtask

    // One clock: check s_ready before the edge, the registered outputs after it.
    task automatic tick();
        logic        er;
        logic [63:0] w;
        #1;
        for (int d = 0; d < 3; d++) begin
            er = !rst && (mode[d] == 2) && (phase[d] == nw[d] - 1) && link_enable;
            check_eq($sformatf("s_ready%0d", d), 64'(rdy[d]), 64'(er));
            if (rdy[d]) rdy_cnt[d]++;
        end
        model_step();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("txdata%0d", d), obs_txd(d), exp_txd[d]);
            check_eq($sformatf("sof%0d", d), 64'(sof[d]), 64'(exp_sof[d]));
            check_eq($sformatf("tx_active%0d", d), 64'(act[d]), 64'(exp_act[d]));
            if (sof[d]) sof_cnt[d]++;
            if (d < 2 && cap_en) begin
                if (sof[d]) begin
                    cap_on[d] = 1'b1;
                    frq[d].push_back(frame[d]);
                end
                if (cap_on[d]) begin
                    w = obs_txd(d);
                    // Undo the word bit order so the stream is frame-MSB first.
                    for (int j = 0; j < dw[d]; j++) bitq[d].push_back(le[d] != 0 ? w[j] : w[dw[d]-1-j]);
                end
            end
        end
    endtask

    // Behavioural receiver: prepend a random slip, hunt for a header lock, then
    // compare recovered frames with those the model sent.
    task automatic loopback(input int d);
        bit          rx[$];
        int          slip;
        int          nfr;
        int          off;
        bit          found;
        bit          ok;
        logic [63:0] fr;
        slip  = $urandom_range(0, 63);
        rx    = {};
        for (int i = 0; i < slip; i++) rx.push_back(1'($urandom()));
        foreach (bitq[d][i]) rx.push_back(bitq[d][i]);
        found = 1'b0;
        off   = 0;
        nfr   = 0;
        for (int o = 0; o < 64 && !found; o++) begin
            ok  = 1'b1;
            nfr = (rx.size() - o) / 64;
            for (int f = 0; f < nfr; f++) begin
                if (rx[o + 64 * f] == rx[o + 64 * f + 1]) ok = 1'b0;
            end
            if (ok && nfr > 0) begin
                found = 1'b1;
                off   = o;
            end
        end
        check_eq($sformatf("rx_aligned%0d", d), 64'(found), 64'd1);
        check_eq($sformatf("rx_slip%0d", d), 64'(off), 64'(slip));
        check_eq($sformatf("rx_frames%0d", d), 64'(nfr >= 40), 64'd1);
        for (int f = 0; f < nfr && f < frq[d].size(); f++) begin
            for (int i = 0; i < 64; i++) fr[63-i] = rx[off + 64 * f + i];
            check_eq($sformatf("rx_frame%0d_%0d", d, f), fr, frq[d][f]);
        end
    endtask

    initial begin
        logic [61:0] pay;
        int          r0;
        int          r2;
        int          s0;
        int          s2;
        int          waited;

        rst         = 1'b1;
        link_enable = 1'b0;
        s_valid     = 1'b0;
        s_ctrl      = 1'b0;
        s_payload   = '0;
        repeat (3) tick();

        // Link off: zero words, sof still periodic.
        rst = 1'b0;
        repeat (8) tick();

        // Training, then RUN.
        link_enable = 1'b1;
        repeat (28) tick();
        check_eq("active_after_train", 64'(act[0]), 64'd1);

        // Held s_valid with an incrementing data payload.
        s_valid = 1'b1;
        s_ctrl  = 1'b0;
        pay     = 62'h0000_0000_0001_0000;
        r0      = rdy_cnt[0];
        r2      = rdy_cnt[2];
        for (int i = 0; i < 40; i++) begin
            s_payload = pay;
            pay       = pay + 62'd1;
            tick();
        end
        check_eq("ready_rate_n4", 64'(rdy_cnt[0] - r0), 64'd10);
        check_eq("ready_rate_n1", 64'(rdy_cnt[2] - r2), 64'd40);

        // No payload: back-to-back idle frames.
        s_valid = 1'b0;
        s0      = sof_cnt[0];
        s2      = sof_cnt[2];
        repeat (20) tick();
        check_eq("sof_rate_n4", 64'(sof_cnt[0] - s0), 64'd5);
        check_eq("sof_rate_n1", 64'(sof_cnt[2] - s2), 64'd20);

        // Loopback capture with random traffic.
        cap_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            s_valid   = 1'($urandom_range(0, 3) != 0);
            s_ctrl    = 1'($urandom_range(0, 3) == 0);
            s_payload = 62'({$urandom(), $urandom()});
            tick();
        end
        cap_en = 1'b0;
        loopback(0);
        loopback(1);

        // Drop the link one word into a frame.
        waited = 0;
        while (phase[0] != 1 && waited < 8) begin
            tick();
            waited++;
        end
        check_eq("found_mid_frame", 64'(phase[0]), 64'd1);
        link_enable = 1'b0;
        s_valid     = 1'b1;
        repeat (20) tick();
        check_eq("inactive_after_drop", 64'(act[0]), 64'd0);

        // Random link toggling, traffic and occasional mid-frame reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) link_enable = ~link_enable;
            rst       = 1'($urandom_range(0, 119) == 0);
            s_valid   = 1'($urandom_range(0, 1));
            s_ctrl    = 1'($urandom_range(0, 1));
            s_payload = 62'({$urandom(), $urandom()});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
